// File: rtl/or_and_pkg.sv
// Shared types for the OR/AND pipeline: function-select encoding, sweep FSM states
// and the truth-table width.
package or_and_pkg;

  localparam int TT_W = 8;

  typedef enum logic [1:0] {
    OR_AND   = 2'b00,
    AND_OR   = 2'b01,
    NOR_NAND = 2'b10,
    XOR_AND  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SWEEP = 2'b01,
    DONE  = 2'b10
  } sweep_state_e;

endpackage

// File: rtl/or_and_func.sv
// Bitwise two-level logic function selected by mode; purely combinational.
module or_and_func
  import or_and_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  mode_e        mode_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (mode_i)
      OR_AND:   y_o = (a_i | b_i) & c_i;
      AND_OR:   y_o = (a_i & b_i) | c_i;
      NOR_NAND: y_o = ~((a_i | b_i) & c_i);
      XOR_AND:  y_o = (a_i ^ b_i) & c_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/or_and_pipe.sv
// Two-stage valid/ready pipeline around or_and_func, plus a sweep FSM that
// captures the 1-bit truth table of a selected mode into tt.
//
// state | meaning
// IDLE  | waiting for sweep_start; pipeline accepts normally
// SWEEP | writes tt[i] for i = 0..7, one per cycle; new accepts blocked
// DONE  | one-cycle completion pulse on sweep_done
module or_and_pipe
  import or_and_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] e,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [TT_W-1:0]  tt,
  output logic [15:0]      res_count
);

  logic             s1_valid_q, s2_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_c_q;
  mode_e            s1_mode_q;
  logic [WIDTH-1:0] e_q, func_y;
  logic [15:0]      res_cnt_q;

  sweep_state_e     state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  mode_e            smode_q, smode_d;
  logic [TT_W-1:0]  tt_q, tt_d;
  logic             sw_y;

  logic accept, adv2, out_fire;

  // A sweep request in IDLE takes priority over an operand set in the same cycle.
  assign in_ready = !rst && (state_q != SWEEP)
                  && (!s1_valid_q || !s2_valid_q || out_ready)
                  && !(state_q == IDLE && sweep_start);
  assign accept   = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;
  assign adv2     = s1_valid_q && (!s2_valid_q || out_ready);

  or_and_func #(.W(WIDTH)) u_func (
    .a_i(s1_a_q), .b_i(s1_b_q), .c_i(s1_c_q), .mode_i(s1_mode_q), .y_o(func_y)
  );

  or_and_func #(.W(1)) u_sweep_func (
    .a_i(idx_q[1]), .b_i(idx_q[0]), .c_i(idx_q[2]), .mode_i(smode_q), .y_o(sw_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s1_mode_q  <= OR_AND;
      s2_valid_q <= 1'b0;
      e_q        <= '0;
      res_cnt_q  <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= a;
        s1_b_q     <= b;
        s1_c_q     <= c;
        s1_mode_q  <= mode_e'(mode);
      end else if (adv2) begin
        s1_valid_q <= 1'b0;
      end
      if (adv2) begin
        s2_valid_q <= 1'b1;
        e_q        <= func_y;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
      if (out_fire) res_cnt_q <= res_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      smode_q <= OR_AND;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      smode_q <= smode_d;
      tt_q    <= tt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    smode_d = smode_q;
    tt_d    = tt_q;
    unique case (state_q)
      IDLE: begin
        if (sweep_start) begin
          state_d = SWEEP;
          smode_d = mode_e'(mode);
          idx_d   = '0;
        end
      end
      SWEEP: begin
        tt_d[idx_q] = sw_y;
        idx_d       = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_valid  = s2_valid_q;
  assign e          = e_q;
  assign res_count  = res_cnt_q;
  assign tt         = tt_q;
  assign sweep_busy = (state_q == SWEEP);
  assign sweep_done = (state_q == DONE);

endmodule

// File: tb/tb_or_and_pipe.sv
// Directed bench for or_and_pipe: single op, all modes, stall, sweeps,
// reset mid-sweep and result-counter wrap; results checked in order by a monitor.
module tb_or_and_pipe;
  import or_and_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] a = '0, b = '0, c = '0, e;
  logic [1:0] mode = '0;
  logic       out_valid, out_ready = 1'b0;
  logic       sweep_start = 1'b0, sweep_busy, sweep_done;
  logic [7:0] tt;
  logic [15:0] res_count;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  logic [7:0] exp_q[$];

  or_and_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .e(e), .sweep_start(sweep_start),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .tt(tt),
    .res_count(res_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, expv, $time);
    end
  endtask

  // In-order scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
      else check("e_order", {24'd0, e}, {24'd0, exp_q.pop_front()});
    end
    if (!rst && sweep_done) done_seen++;
  end

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; sweep_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] tc,
                      input logic [1:0] tm, input logic [7:0] texp);
    int n = 0;
    a = ta; b = tb_; c = tc; mode = tm; in_valid = 1'b1;
    exp_q.push_back(texp);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_sweep(input logic [1:0] tm, input logic [7:0] tt_exp);
    int n = 0;
    mode = tm; sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    @(negedge clk);
    while (sweep_busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("sweep_busy_len", n, 32'd8);
    check("sweep_done_hi", {31'd0, sweep_done}, 32'd1);
    @(negedge clk);
    check("sweep_done_pulse", {31'd0, sweep_done}, 32'd0);
    check("sweep_tt", {24'd0, tt}, {24'd0, tt_exp});
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_e", {24'd0, e}, 32'd0);
    check("rst_tt", {24'd0, tt}, 32'd0);
    check("rst_res_count", {16'd0, res_count}, 32'd0);
    check("rst_busy_done", {30'd0, sweep_busy, sweep_done}, 32'd0);

    // Single transaction: latency of two edges from the accept cycle.
    @(posedge clk); #1;
    out_ready = 1'b1;
    a = 8'h0F; b = 8'hF0; c = 8'h3C; mode = 2'b00; in_valid = 1'b1;
    exp_q.push_back(8'h3C);
    @(negedge clk);
    check("single_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("single_ov_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("single_ov", {31'd0, out_valid}, 32'd1);
    check("single_e", {24'd0, e}, 32'h3C);
    @(negedge clk);
    check("single_count", {16'd0, res_count}, 32'd1);

    // All four modes back to back.
    @(posedge clk); #1;
    send(8'hA5, 8'h5A, 8'h0F, 2'b00, 8'h0F);
    send(8'hA5, 8'h5A, 8'h0F, 2'b01, 8'h0F);
    send(8'hA5, 8'h5A, 8'h0F, 2'b10, 8'hF0);
    send(8'hA5, 8'h5A, 8'h0F, 2'b11, 8'h0F);
    repeat (3) @(negedge clk);
    check("modes_drained", exp_q.size(), 32'd0);
    check("modes_count", {16'd0, res_count}, 32'd5);

    // Stall with out_ready low.
    do_reset();
    out_ready = 1'b0;
    send(8'h0F, 8'hF0, 8'h3C, 2'b00, 8'h3C);
    send(8'hFF, 8'h0F, 8'h10, 2'b01, 8'h1F);
    a = 8'h33; b = 8'h0F; c = 8'hF0; mode = 2'b11; in_valid = 1'b1;
    @(negedge clk);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (4) @(negedge clk);
    check("stall_in_ready_5", {31'd0, in_ready}, 32'd0);
    check("stall_ov", {31'd0, out_valid}, 32'd1);
    check("stall_e_hold", {24'd0, e}, 32'h3C);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h33, 8'h0F, 8'hF0, 2'b11, 8'h30);
    repeat (4) @(negedge clk);
    check("stall_drained", exp_q.size(), 32'd0);
    check("stall_count", {16'd0, res_count}, 32'd3);

    // Sweeps in every mode.
    @(posedge clk); #1;
    run_sweep(2'b00, 8'hE0);
    @(posedge clk); #1;
    run_sweep(2'b01, 8'hF8);
    @(posedge clk); #1;
    run_sweep(2'b10, 8'h1F);
    @(posedge clk); #1;
    run_sweep(2'b11, 8'h60);

    // Sweep wins over a simultaneous operand set.
    @(posedge clk); #1;
    a = 8'h01; b = 8'h02; c = 8'hFF; mode = 2'b00; in_valid = 1'b1; sweep_start = 1'b1;
    @(negedge clk);
    check("sweep_wins_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; sweep_start = 1'b0;
    repeat (12) @(negedge clk);
    check("sweep_wins_count", {16'd0, res_count}, 32'd3);

    // Reset asserted at the 4th sweep cycle.
    done_seen = 0;
    @(posedge clk); #1;
    mode = 2'b01; sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_tt", {24'd0, tt}, 32'd0);
    check("rst_mid_state", {30'd0, dut.state_q}, {30'd0, IDLE});
    check("rst_mid_busy", {31'd0, sweep_busy}, 32'd0);
    check("rst_mid_count", {16'd0, res_count}, 32'd0);
    repeat (12) @(negedge clk);
    check("rst_mid_no_done", done_seen, 32'd0);

    // Counter wrap after 65537 handshakes.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 65537; k++) send(8'h0F, 8'hF0, 8'h3C, 2'b00, 8'h3C);
    repeat (4) @(negedge clk);
    check("wrap_drained", exp_q.size(), 32'd0);
    check("wrap_count", {16'd0, res_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/or_and_pipe.md
OR_AND_PIPE -- requirements
Module: or_and_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-006 The block SHALL have ports a, b and c, input, WIDTH bits each: the operands.
REQ-007 The block SHALL have port mode, input, 2 bits: function select, sampled with the operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result e is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream consumer takes e.
REQ-010 The block SHALL have port e, output, WIDTH bits: the result.
REQ-011 The block SHALL have port sweep_start, input, 1 bit: request a truth-table sweep.
REQ-012 The block SHALL have port sweep_busy, output, 1 bit: a sweep is in progress.
REQ-013 The block SHALL have port sweep_done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-014 The block SHALL have port tt, output, 8 bits: the truth table captured by the last sweep.
REQ-015 The block SHALL have port res_count, output, 16 bits: the number of completed output handshakes.

Function
REQ-016 The block SHALL compute its result bitwise per mode: 00 OR_AND = (a|b)&c; 01 AND_OR = (a&b)|c; 10 NOR_NAND = ~((a|b)&c); 11 XOR_AND = (a^b)&c.
REQ-017 The block SHALL accept an operand set when in_valid && in_ready; a, b, c and mode are captured into stage 1 at that cycle.
REQ-018 The block SHALL register the stage-1 operands into stage 2 as the function result, and stage 2 drives e and out_valid.
REQ-019 The block SHALL assert out_valid exactly 2 cycles after the accepting edge when it is not stalled.
REQ-020 The block SHALL sustain one accept per cycle when out_ready is held high.
REQ-021 The block SHALL hold e and out_valid stable while out_valid && !out_ready.
REQ-022 The block SHALL advance stage 1 into stage 2 only when stage 2 is empty or out_ready is high.
REQ-023 The block SHALL drive in_ready = !rst && !sweep_busy && (!s1_valid || !s2_valid || out_ready).
REQ-024 The block SHALL preserve data order, and no result shall be lost or duplicated under any out_ready pattern.
REQ-025 The block SHALL increment res_count on each out_valid && out_ready cycle; res_count wraps from 16'hFFFF to 0.
REQ-026 The sweep FSM SHALL have the states IDLE, SWEEP and DONE.
REQ-027 The sweep FSM SHALL move from IDLE to SWEEP when sweep_start is high, latching mode and clearing the index i to 0.
REQ-028 In SWEEP, each cycle the block SHALL evaluate 1-bit A=i[1], B=i[0], C=i[2] in the latched mode, write the result into tt[i], and increment i.
REQ-029 The sweep FSM SHALL move from SWEEP to DONE after i=7 is written, so a sweep lasts exactly 8 cycles.
REQ-030 The sweep FSM SHALL move from DONE to IDLE unconditionally after one cycle.
REQ-031 The block SHALL assert sweep_busy exactly in the SWEEP state, and sweep_done exactly in the DONE state.
REQ-032 The block SHALL ignore sweep_start in SWEEP and DONE states.
REQ-033 The block SHALL hold tt from sweep end until the next sweep, and tt bits SHALL update progressively during a sweep.
REQ-034 During a sweep the pipeline SHALL keep draining (stages advance per REQ-022), and only new accepts are blocked.
REQ-035 When sweep_start and in_valid are both high in the same IDLE cycle, the sweep SHALL win and no accept SHALL occur that cycle.

Reset
REQ-036 The block SHALL drive all of the following to 0 while rst is high on a clock edge: s1_valid, s2_valid, out_valid, e, tt, res_count, i, sweep_busy, sweep_done.
REQ-037 The sweep FSM SHALL be in IDLE after reset.
REQ-038 The block SHALL discard any in-flight data or partial sweep when reset is asserted mid-operation, and no sweep_done SHALL be produced for it.
REQ-039 The block SHALL hold in_ready at 0 while rst is high.

Structure
REQ-040 Package or_and_pkg SHALL hold the mode encoding enum (OR_AND, AND_OR, NOR_NAND, XOR_AND), the sweep state enum (IDLE, SWEEP, DONE) and the constant TT_W = 8.
REQ-041 Combinational sub-module or_and_func, parametrised by width, SHALL implement REQ-016.
REQ-042 The top level SHALL instantiate or_and_func twice: once at WIDTH for the pipeline and once at width 1 for the sweep.

Verification
REQ-043 The bench SHALL cover a single transaction: WIDTH=8, mode=00, a=8'h0F, b=8'hF0, c=8'h3C, out_ready=1 -> e=8'h3C with out_valid high 2 cycles after accept, res_count=1.
REQ-044 The bench SHALL cover all four modes with a=8'hA5, b=8'h5A, c=8'h0F, in mode order 00 to 11 -> e sequence 8'h0F, 8'h0F, 8'hF0, 8'h0F on consecutive cycles.
REQ-045 The bench SHALL cover a stall: 3 back-to-back accepts with out_ready=0 for 5 cycles -> in_ready falls after 2 accepts, e holds the first result; on release all 3 results arrive in order, res_count=3.
REQ-046 The bench SHALL cover sweeps: sweep_start in each mode -> sweep_busy high for 8 cycles, then a one-cycle sweep_done, with tt = 8'hE0 (00), 8'hF8 (01), 8'h1F (10), 8'h60 (11).
REQ-047 The bench SHALL cover reset mid-sweep: rst at the 4th sweep cycle -> tt=0, IDLE state, no sweep_done, res_count=0.
REQ-048 The bench SHALL cover counter wrap: res_count preloaded near the limit by 65537 handshakes -> res_count=1.
